// File: rtl/controller.sv
// Eight-phase instruction sequencer for the accumulator CPU.
// Outputs decode the current phase, opcode and zero flag.
module controller #(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] opcode,
  input  logic       is_zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       halt,
  output logic       ld_pc,
  output logic       data_e,
  output logic       ld_ac,
  output logic       wr,
  output logic [2:0] phase
);

  localparam logic [2:0] INST_ADDR  = 3'd0;
  localparam logic [2:0] INST_FETCH = 3'd1;
  localparam logic [2:0] INST_LOAD  = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] OP_ADDR    = 3'd4;
  localparam logic [2:0] OP_FETCH   = 3'd5;
  localparam logic [2:0] ALU_OP     = 3'd6;
  localparam logic [2:0] STORE      = 3'd7;

  localparam logic [2:0] OPC_HLT = 3'b000;
  localparam logic [2:0] OPC_SKZ = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_AND = 3'b011;
  localparam logic [2:0] OPC_XOR = 3'b100;
  localparam logic [2:0] OPC_LDA = 3'b101;
  localparam logic [2:0] OPC_STO = 3'b110;
  localparam logic [2:0] OPC_JMP = 3'b111;

  logic [2:0] state_q, state_d;
  logic       halted_q, halted_d;
  logic       alu_op, is_hlt, frz;

  assign alu_op = (opcode == OPC_ADD) || (opcode == OPC_AND) ||
                  (opcode == OPC_XOR) || (opcode == OPC_LDA);
  assign is_hlt = (opcode == OPC_HLT);
  // Sticky halt: once frozen, opcode no longer matters.
  assign frz    = HALT_STICKY && (is_hlt || halted_q);
  assign phase  = state_q;

  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        INST_ADDR:  state_d = INST_FETCH;
        INST_FETCH: state_d = INST_LOAD;
        INST_LOAD:  state_d = IDLE;
        IDLE:       state_d = OP_ADDR;
        OP_ADDR: begin
          if (HALT_STICKY && is_hlt) halted_d = 1'b1;
          else                       state_d  = OP_FETCH;
        end
        OP_FETCH:   state_d = ALU_OP;
        ALU_OP:     state_d = STORE;
        STORE:      state_d = INST_ADDR;
        default:    state_d = INST_ADDR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    case (state_q)
      INST_ADDR: sel = 1'b1;
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        halt   = is_hlt || halted_q;
        inc_pc = !frz;
      end
      OP_FETCH: rd = alu_op;
      ALU_OP: begin
        rd     = alu_op;
        inc_pc = (opcode == OPC_SKZ) && is_zero;
        ld_pc  = (opcode == OPC_JMP);
        data_e = (opcode == OPC_STO);
      end
      STORE: begin
        rd     = alu_op;
        ld_ac  = alu_op;
        ld_pc  = (opcode == OPC_JMP);
        inc_pc = (opcode == OPC_JMP);
        data_e = (opcode == OPC_STO);
        wr     = (opcode == OPC_STO);
      end
      default: sel = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Bench for controller: sticky and pulse halt instances
// driven together, checked against a phase model via queues.
module tb_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic       is_zero;

  logic [1:0] sel, rd, ld_ir, inc_pc, halt;
  logic [1:0] ld_pc, data_e, ld_ac, wr;
  logic [2:0] phase [2];

  int n_chk = 0;
  int n_err = 0;

  logic [11:0] exp_q [2][$];
  logic [2:0]  m_st [2];
  logic        m_hl [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    controller #(.HALT_STICKY(k == 1)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .opcode (opcode),
      .is_zero(is_zero),
      .sel    (sel[k]),
      .rd     (rd[k]),
      .ld_ir  (ld_ir[k]),
      .inc_pc (inc_pc[k]),
      .halt   (halt[k]),
      .ld_pc  (ld_pc[k]),
      .data_e (data_e[k]),
      .ld_ac  (ld_ac[k]),
      .wr     (wr[k]),
      .phase  (phase[k])
    );
  end

  task automatic check(string tag, logic [11:0] got,
                       logic [11:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%03h exp=%03h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_out(
    logic [2:0] s, logic h, logic [2:0] op, logic z, bit stk);
    logic a, o_sel, o_rd, o_ir, o_inc, o_hlt;
    logic o_ldpc, o_de, o_ldac, o_wr;
    a = (op == 3'd2) || (op == 3'd3) ||
        (op == 3'd4) || (op == 3'd5);
    {o_sel, o_rd, o_ir, o_inc, o_hlt} = '0;
    {o_ldpc, o_de, o_ldac, o_wr} = '0;
    case (s)
      3'd0: o_sel = 1;
      3'd1: {o_sel, o_rd} = 2'b11;
      3'd2, 3'd3: {o_sel, o_rd, o_ir} = 3'b111;
      3'd4: begin
        o_hlt = (op == 3'd0) || h;
        o_inc = !(stk && o_hlt);
      end
      3'd5: o_rd = a;
      3'd6: begin
        o_rd   = a;
        o_inc  = (op == 3'd1) && z;
        o_ldpc = (op == 3'd7);
        o_de   = (op == 3'd6);
      end
      default: begin
        o_rd   = a;
        o_ldac = a;
        o_ldpc = (op == 3'd7);
        o_inc  = (op == 3'd7);
        o_de   = (op == 3'd6);
        o_wr   = (op == 3'd6);
      end
    endcase
    return {s, o_sel, o_rd, o_ir, o_inc, o_hlt,
            o_ldpc, o_de, o_ldac, o_wr};
  endfunction

  function automatic logic [11:0] dut_out(int k);
    return {phase[k], sel[k], rd[k], ld_ir[k], inc_pc[k],
            halt[k], ld_pc[k], data_e[k], ld_ac[k], wr[k]};
  endfunction

  // One clock: drive at negedge, check, glitch rst_n mid-cycle.
  task automatic cyc(logic [2:0] op, logic z, logic rn,
                     string tag);
    @(negedge clk);
    opcode  = op;
    is_zero = z;
    rst_n   = rn;
    for (int k = 0; k < 2; k++)
      exp_q[k].push_back(model_out(m_st[k], m_hl[k], op, z,
                                   k == 1));
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("%s_s%0d_p%0d", tag, k, m_st[k]),
            dut_out(k), exp_q[k].pop_front());
    if (rn) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rn) begin
        m_st[k] = 3'd0;
        m_hl[k] = 1'b0;
      end else if (m_hl[k]) begin
        m_st[k] = m_st[k];
      end else if (k == 1 && m_st[k] == 3'd4 && op == 3'd0) begin
        m_hl[k] = 1'b1;
      end else begin
        m_st[k] = m_st[k] + 3'd1;
      end
    end
  endtask

  task automatic reset_n(int n);
    repeat (n) cyc(3'd2, 1'b0, 1'b0, "rst");
  endtask

  initial begin
    rst_n   = 1'b0;
    opcode  = 3'd0;
    is_zero = 1'b0;
    m_st    = '{3'd0, 3'd0};
    m_hl    = '{1'b0, 1'b0};
    @(posedge clk);
    @(posedge clk);
    reset_n(2);
    repeat (8) cyc(3'd2, 1'b0, 1'b1, "add");
    repeat (8) cyc(3'd6, 1'b1, 1'b1, "sto");
    repeat (8) cyc(3'd1, 1'b1, 1'b1, "skz1");
    repeat (8) cyc(3'd1, 1'b0, 1'b1, "skz0");
    repeat (8) cyc(3'd7, 1'b0, 1'b1, "jmp");
    for (int op = 2; op < 6; op++)
      repeat (8) cyc(3'(op), 1'($urandom_range(1)), 1'b1, "alu");
    reset_n(1);
    repeat (7) cyc(3'd0, 1'b0, 1'b1, "hlt");
    reset_n(1);
    repeat (5) cyc(3'd0, 1'b0, 1'b1, "hlt2");
    repeat (12)
      cyc(3'($urandom_range(7)), 1'($urandom_range(1)), 1'b1,
          "held");
    reset_n(1);
    repeat (4) cyc(3'd2, 1'b0, 1'b1, "post");
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
